spike_decoder: RTL and testbench

SPIKE_DECODER -- requirements
Module: spike_decoder

---
 rtl/stdp_pkg.sv | 12 +
 rtl/spike_decoder_if.sv | 30 +++
 rtl/sat_counter.sv | 25 ++
 rtl/spike_decoder.sv | 151 +++++++++++++++
 tb/tb_spike_decoder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared constants and FSM encoding for the spike decoder
package stdp_pkg;

  localparam int WIN_W_DEF = 12;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;

endpackage

// File: rtl/spike_decoder_if.sv
// rtl/spike_decoder_if.sv - decoded result bus: window rate and inter-spike interval
interface spike_decoder_if
  import stdp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             overflow;
  logic [CNT_W-1:0] isi;
  logic             isi_valid;

  modport master (
    output rate,
    output rate_valid,
    output overflow,
    output isi,
    output isi_valid
  );

  modport slave (
    input rate,
    input rate_valid,
    input overflow,
    input isi,
    input isi_valid
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; clear restarts the count at the current increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = &value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= {{(W-1){1'b0}}, inc};
    end else if (inc && !at_max) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// rtl/spike_decoder.sv - windowed spike-rate decoder; ISI timer compiled in with SPIKE_ISI_EN
module spike_decoder
  import stdp_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  input  logic [WIN_W-1:0] window_len,
  spike_decoder_if.master  dec
);

  dec_state_t       state_q, state_d;
  logic [WIN_W-1:0] timer_q;
  logic [WIN_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] rate_d;
  logic [CNT_W-1:0] rate_q;
  logic             cnt_max;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             win_end;
  logic             rate_valid_q;
  logic             overflow_q;

  assign len_eff = (window_len == '0) ? WIN_W'(1) : window_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The last window cycle's spike goes straight into rate, so it never reaches the counter.
  always_comb begin
    state_d   = state_q;
    win_end   = 1'b0;
    cnt_clear = 1'b1;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = COUNT;
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          win_end   = (timer_q == WIN_W'(1));
          cnt_clear = win_end;
          cnt_inc   = spike && !win_end;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rate_d = (spike && !cnt_max) ? cnt_val + CNT_W'(1) : cnt_val;

  sat_counter #(
    .W (CNT_W)
  ) u_rate_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .value  (cnt_val),
    .at_max (cnt_max)
  );

  // Timer counts down the cycles left in the window and reloads on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (en) begin
      if (state_q == IDLE || win_end) begin
        timer_q <= len_eff;
      end else begin
        timer_q <= timer_q - WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q       <= '0;
      overflow_q   <= 1'b0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= win_end;
      if (win_end) begin
        rate_q     <= rate_d;
        overflow_q <= spike && cnt_max;
      end
    end
  end

  assign dec.rate       = rate_q;
  assign dec.rate_valid = rate_valid_q;
  assign dec.overflow   = overflow_q;

`ifdef SPIKE_ISI_EN
  logic [CNT_W-1:0] isi_val;
  logic [CNT_W-1:0] isi_q;
  logic             isi_max;
  logic             isi_valid_q;
  logic             armed_q;
  logic             isi_hit;

  // Each spike restarts the timer at 1 so a spike three cycles later reads 3.
  sat_counter #(
    .W (CNT_W)
  ) u_isi_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!en || spike),
    .inc    (en && !isi_max),
    .value  (isi_val),
    .at_max (isi_max)
  );

  assign isi_hit = en && spike && armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_valid_q <= isi_hit;
      if (isi_hit) isi_q <= isi_val;
      if (!en) begin
        armed_q <= 1'b0;
      end else if (spike) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign dec.isi       = isi_q;
  assign dec.isi_valid = isi_valid_q;
`else
  assign dec.isi       = '0;
  assign dec.isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_decoder.sv
// tb/tb_spike_decoder.sv - directed vector bench for spike_decoder
module tb_spike_decoder;
  import stdp_pkg::*;

  localparam int WIN_W = 12;
  localparam int CNT_W = 8;
`ifdef SPIKE_ISI_EN
  localparam bit ISI_ON = 1'b1;
`else
  localparam bit ISI_ON = 1'b0;
`endif

  typedef struct {
    logic             en;
    logic             spike;
    logic [WIN_W-1:0] wl;
    logic [CNT_W-1:0] rate;
    logic             rv;
    logic             ov;
    logic [CNT_W-1:0] isi;
    logic             isiv;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             spike = 1'b0;
  logic [WIN_W-1:0] window_len = '0;

  int n_cmp = 0;
  int n_bad = 0;

  spike_decoder_if #(.CNT_W(CNT_W)) dec_if ();

  spike_decoder #(
    .WIN_W (WIN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike      (spike),
    .window_len (window_len),
    .dec        (dec_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic s);
    en    = e;
    spike = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    spike = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic e, input logic s, input int wl, input int rate,
                              input logic rv, input logic ov, input int isi, input logic isiv);
    vec_t v;
    v.en    = e;
    v.spike = s;
    v.wl    = WIN_W'(wl);
    v.rate  = CNT_W'(rate);
    v.rv    = rv;
    v.ov    = ov;
    v.isi   = ISI_ON ? CNT_W'(isi) : '0;
    v.isiv  = ISI_ON ? isiv : 1'b0;
    return v;
  endfunction

  vec_t vec [11];

  initial begin
    vec[0]  = mk(0, 1, 2, 0, 0, 0, 0, 0);
    vec[1]  = mk(1, 1, 2, 0, 0, 0, 0, 0);
    vec[2]  = mk(1, 1, 2, 0, 0, 0, 1, 1);
    vec[3]  = mk(1, 1, 2, 2, 1, 0, 1, 1);
    vec[4]  = mk(1, 0, 3, 2, 0, 0, 1, 0);
    vec[5]  = mk(1, 1, 3, 1, 1, 0, 2, 1);
    vec[6]  = mk(1, 1, 3, 1, 0, 0, 1, 1);
    vec[7]  = mk(1, 0, 3, 1, 0, 0, 1, 0);
    vec[8]  = mk(1, 1, 3, 2, 1, 0, 2, 1);
    vec[9]  = mk(0, 1, 3, 2, 0, 0, 2, 0);
    vec[10] = mk(0, 1, 3, 2, 0, 0, 2, 0);

    #1;
    chk("reset_rate", dec_if.rate, 0);
    chk("reset_rv", dec_if.rate_valid, 0);
    chk("reset_ov", dec_if.overflow, 0);
    chk("reset_isi", dec_if.isi, 0);
    chk("reset_isiv", dec_if.isi_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table: short windows, mid-window length change, en drop
    do_reset();
    for (int i = 0; i < 11; i++) begin
      window_len = vec[i].wl;
      cyc(vec[i].en, vec[i].spike);
      chk($sformatf("vec%0d_rate", i), dec_if.rate, vec[i].rate);
      chk($sformatf("vec%0d_rv", i), dec_if.rate_valid, vec[i].rv);
      chk($sformatf("vec%0d_ov", i), dec_if.overflow, vec[i].ov);
      chk($sformatf("vec%0d_isi", i), dec_if.isi, vec[i].isi);
      chk($sformatf("vec%0d_isiv", i), dec_if.isi_valid, vec[i].isiv);
    end

    // window 10, spike every 2nd cycle
    do_reset();
    window_len = 10;
    cyc(1, 0);
    chk("w10_en_rv", dec_if.rate_valid, 0);
    for (int c = 1; c <= 30; c++) begin
      cyc(1, logic'(c % 2));
      chk("w10_rv", dec_if.rate_valid, (c % 10 == 0));
      if (c % 10 == 0) begin
        chk("w10_rate", dec_if.rate, 5);
        chk("w10_ov", dec_if.overflow, 0);
      end
    end

    // window 300, spike held high: saturation
    do_reset();
    window_len = 300;
    cyc(1, 1);
    for (int c = 1; c <= 600; c++) begin
      cyc(1, 1);
      chk("w300_rv", dec_if.rate_valid, (c % 300 == 0));
      if (c % 300 == 0) begin
        chk("w300_rate", dec_if.rate, 255);
        chk("w300_ov", dec_if.overflow, 1);
      end
    end

    // en dropped mid-window discards the partial count
    do_reset();
    window_len = 10;
    cyc(1, 0);
    for (int c = 1; c <= 10; c++) cyc(1, logic'(c <= 3));
    chk("drop_pre_rate", dec_if.rate, 3);
    chk("drop_pre_rv", dec_if.rate_valid, 1);
    for (int c = 1; c <= 4; c++) cyc(1, 1);
    for (int c = 0; c < 4; c++) begin
      cyc(0, 1);
      chk("drop_rv", dec_if.rate_valid, 0);
      chk("drop_rate", dec_if.rate, 3);
    end
    cyc(1, 1);
    chk("reen_rv", dec_if.rate_valid, 0);
    for (int c = 1; c <= 10; c++) begin
      cyc(1, logic'(c <= 2));
      chk("reen_rv", dec_if.rate_valid, (c == 10));
    end
    chk("reen_rate", dec_if.rate, 2);

    // window_len 0 behaves as 1
    do_reset();
    window_len = 0;
    cyc(1, 1);
    chk("w0_en_rv", dec_if.rate_valid, 0);
    for (int c = 1; c <= 5; c++) begin
      cyc(1, 1);
      chk("w0_rv", dec_if.rate_valid, 1);
      chk("w0_rate", dec_if.rate, 1);
    end
    cyc(1, 0);
    chk("w0_rate_lo", dec_if.rate, 0);
    chk("w0_rv_lo", dec_if.rate_valid, 1);
    cyc(1, 1);
    chk("w0_rate_hi", dec_if.rate, 1);

    // ISI: spikes at 3, 7, 400
    do_reset();
    window_len = 10;
    for (int t = 0; t <= 402; t++) begin
      cyc(1, logic'(t == 3 || t == 7 || t == 400));
      chk("isi_valid", dec_if.isi_valid, ISI_ON && (t == 7 || t == 400));
      if (t == 3 || t == 7 || t == 8 || t == 400 || t == 401) begin
        chk("isi_val", dec_if.isi, !ISI_ON ? 0 : (t < 7) ? 0 : (t < 400) ? 4 : 255);
      end
    end

    // async reset mid-window clears outputs without a clock edge
    do_reset();
    window_len = 10;
    cyc(1, 0);
    for (int c = 1; c <= 10; c++) cyc(1, logic'(c <= 5));
    chk("rst_pre_rate", dec_if.rate, 5);
    for (int c = 1; c <= 5; c++) cyc(1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rate", dec_if.rate, 0);
    chk("rst_rv", dec_if.rate_valid, 0);
    chk("rst_ov", dec_if.overflow, 0);
    chk("rst_isi", dec_if.isi, 0);
    chk("rst_isiv", dec_if.isi_valid, 0);
    #1;
    rst_n = 1'b1;
    cyc(0, 1);
    cyc(0, 1);
    chk("post_rst_idle_rv", dec_if.rate_valid, 0);
    chk("post_rst_idle_rate", dec_if.rate, 0);
    window_len = 1;
    cyc(1, 1);
    chk("post_rst_en_rv", dec_if.rate_valid, 0);
    cyc(1, 1);
    chk("post_rst_rv", dec_if.rate_valid, 1);
    chk("post_rst_rate", dec_if.rate, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
